// File: rtl/sr_flag_sequencer.sv
// -----------------------------------------------------------------------------
// sr_flag_sequencer
// Arbitrates SET / CLEAR requests for a bank of clocked SR status flags,
// issues a single one-cycle s or r pulse to the addressed flag and waits for
// the flag's q to confirm the new value before acknowledging.
// s and r can only be driven from the DRIVE state, and only one of them per
// operation, so the bank never sees S=R=1.
// -----------------------------------------------------------------------------
module sr_flag_sequencer #(
    parameter int NUM_FLAGS = 4,
    parameter int IDX_W     = 2,
    parameter int TIMEOUT   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set_req,
    input  logic [IDX_W-1:0]     set_idx,
    input  logic                 clr_req,
    input  logic [IDX_W-1:0]     clr_idx,
    input  logic [NUM_FLAGS-1:0] q_in,
    output logic [NUM_FLAGS-1:0] s_out,
    output logic [NUM_FLAGS-1:0] r_out,
    output logic                 set_ack,
    output logic                 clr_ack,
    output logic                 err,
    output logic                 busy
);

    // Counter is one bit wider than needed for TIMEOUT-1 so it can never wrap
    // before the timeout compare fires.
    localparam int                CNT_W      = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W:0]    NUM_FLAGS_C = (IDX_W + 1)'(NUM_FLAGS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t                 r_state;
    logic                   r_prio_set;   // 1: SET wins the next contention
    logic                   r_op_set;     // granted operation: 1 = SET, 0 = CLEAR
    logic [NUM_FLAGS-1:0]   r_mask;       // one-hot mask of the granted flag
    logic [CNT_W-1:0]       r_cnt;

    logic                   w_any_req;
    logic                   w_contend;
    logic                   w_grant_set;
    logic [IDX_W-1:0]       w_gidx;
    logic                   w_idx_ok;
    logic [NUM_FLAGS-1:0]   w_gmask;
    logic                   w_q_sel;
    logic                   w_match;

    // Grant decision for the IDLE state: lone requester wins, contention goes to prio
    always_comb begin
        w_any_req   = set_req | clr_req;
        w_contend   = set_req & clr_req;
        w_grant_set = set_req & (~clr_req | r_prio_set);
        w_gidx      = w_grant_set ? set_idx : clr_idx;
        w_idx_ok    = ({1'b0, w_gidx} < NUM_FLAGS_C);
        w_gmask     = NUM_FLAGS'(1) << w_gidx;
    end

    // Confirmation compare: selected q against the value the operation should produce
    always_comb begin
        w_q_sel = |(q_in & r_mask);
        w_match = (w_q_sel == r_op_set);
    end

    // Sequencer FSM with registered pulse, handshake and busy outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_prio_set <= 1'b1;
            r_op_set   <= 1'b0;
            r_mask     <= '0;
            r_cnt      <= '0;
            s_out      <= '0;
            r_out      <= '0;
            set_ack    <= 1'b0;
            clr_ack    <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b0;
        end else begin
            // Pulses last one cycle unless a state below re-asserts them
            s_out   <= '0;
            r_out   <= '0;
            set_ack <= 1'b0;
            clr_ack <= 1'b0;
            err     <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        busy     <= 1'b1;
                        r_op_set <= w_grant_set;
                        r_mask   <= w_gmask;
                        if (w_contend) begin
                            r_prio_set <= ~r_prio_set;
                        end
                        if (w_idx_ok) begin
                            // The pulse is registered here so it is live during DRIVE
                            r_state <= ST_DRIVE;
                            if (w_grant_set) begin
                                s_out <= w_gmask;
                            end else begin
                                r_out <= w_gmask;
                            end
                        end else begin
                            // Nonexistent flag: report without touching the bank
                            r_state <= ST_RESP;
                            err     <= 1'b1;
                        end
                    end
                end

                ST_DRIVE: begin
                    r_state <= ST_CHECK;
                    r_cnt   <= '0;
                end

                ST_CHECK: begin
                    if (w_match) begin
                        r_state <= ST_RESP;
                        set_ack <= r_op_set;
                        clr_ack <= ~r_op_set;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= ST_RESP;
                        err     <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                ST_RESP: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end

                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_flag_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sr_flag_sequencer
// Directed and randomized checks of sr_flag_sequencer driving a behavioural
// SR flag bank. A second instance with three flags exercises the bad-index path.
// -----------------------------------------------------------------------------
module tb_sr_flag_sequencer;

    localparam int NF = 4;
    localparam int IW = 2;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          set_req, clr_req;
    logic [IW-1:0] set_idx, clr_idx;
    logic [NF-1:0] q_bank = '0;
    logic [NF-1:0] q_in, s_out, r_out;
    logic          set_ack, clr_ack, err, busy;
    logic          stuck0;

    logic          set_req3, clr_req3;
    logic [1:0]    set_idx3, clr_idx3;
    logic [2:0]    q_in3, s_out3, r_out3;
    logic          set_ack3, clr_ack3, err3, busy3;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sr_flag_sequencer #(.NUM_FLAGS(NF), .IDX_W(IW), .TIMEOUT(TO)) u_dut (
        .clk(clk), .rst(rst),
        .set_req(set_req), .set_idx(set_idx),
        .clr_req(clr_req), .clr_idx(clr_idx),
        .q_in(q_in), .s_out(s_out), .r_out(r_out),
        .set_ack(set_ack), .clr_ack(clr_ack), .err(err), .busy(busy)
    );

    sr_flag_sequencer #(.NUM_FLAGS(3), .IDX_W(2), .TIMEOUT(TO)) u_dut3 (
        .clk(clk), .rst(rst),
        .set_req(set_req3), .set_idx(set_idx3),
        .clr_req(clr_req3), .clr_idx(clr_idx3),
        .q_in(q_in3), .s_out(s_out3), .r_out(r_out3),
        .set_ack(set_ack3), .clr_ack(clr_ack3), .err(err3), .busy(busy3)
    );

    // Clocked SR flip-flop bank (S has precedence only for modelling; the DUT never asserts both)
    always @(posedge clk) begin
        for (int i = 0; i < NF; i++) begin
            if (s_out[i])      q_bank[i] <= 1'b1;
            else if (r_out[i]) q_bank[i] <= 1'b0;
        end
    end

    assign q_in  = q_bank & ~{{(NF-1){1'b0}}, stuck0};
    assign q_in3 = 3'b000;

    function automatic logic [NF-1:0] oh(input logic [IW-1:0] i);
        logic [NF-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Waits (bounded) for any response pulse; f = {set_ack, clr_ack, err}, 0 if none came
    task automatic wait_resp(output int cyc, output logic [2:0] f);
        cyc = 0;
        f   = 3'b000;
        for (int k = 0; k < 40 && f == 3'b000; k++) begin
            tick();
            cyc++;
            f = {set_ack, clr_ack, err};
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int         cyc;
        logic [2:0] f;
        // random-traffic model state
        bit         prev_busy, m_prio_set, m_active, m_side_set, m_exp_err, gs, dropped_s, dropped_c;
        logic [IW-1:0] m_idx;
        int         m_pulses, m_dur, nreq, nresp;

        rst = 1'b1; set_req = 0; clr_req = 0; set_idx = '0; clr_idx = '0; stuck0 = 0;
        set_req3 = 0; clr_req3 = 0; set_idx3 = '0; clr_idx3 = '0;

        // Reset state
        tick(); tick();
        chk("rst_s_out", s_out, 0);
        chk("rst_r_out", r_out, 0);
        chk("rst_set_ack", set_ack, 0);
        chk("rst_clr_ack", clr_ack, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        tick();

        // Single SET on flag 2
        set_idx = 2; set_req = 1;
        tick();
        chk("t2_drive_s", s_out, 4'b0100);
        chk("t2_drive_r", r_out, 0);
        chk("t2_busy", busy, 1);
        tick();
        chk("t2_s_one_cycle", s_out, 0);
        chk("t2_q2", q_in[2], 1);
        chk("t2_no_early_ack", set_ack, 0);
        tick();
        chk("t2_resp", {set_ack, clr_ack, err}, 3'b100);
        set_req = 0;
        tick();
        chk("t2_ack_pulse", set_ack, 0);
        chk("t2_busy_low", busy, 0);

        // Asynchronous reset in the middle of DRIVE
        set_idx = 1; set_req = 1;
        tick();
        chk("t1_drive_s", s_out, 4'b0010);
        #2 rst = 1'b1;
        #1;
        chk("t1_async_s", s_out, 0);
        chk("t1_async_busy", busy, 0);
        tick();
        chk("t1_no_ack", {set_ack, clr_ack, err}, 3'b000);
        rst = 1'b0;
        tick();
        chk("t1_regrant_busy", busy, 1);
        chk("t1_regrant_s", s_out, 4'b0010);
        wait_resp(cyc, f);
        chk("t1_resp", f, 3'b100);
        chk("t1_latency", cyc, 2);
        set_req = 0;
        tick();

        // Preset flag 3, then contention from a fresh reset
        set_idx = 3; set_req = 1;
        wait_resp(cyc, f);
        chk("t3_preset_resp", f, 3'b100);
        set_req = 0;
        tick();
        chk("t3_preset_q3", q_in[3], 1);
        rst = 1'b1; tick(); rst = 1'b0; tick();

        set_idx = 1; set_req = 1; clr_idx = 3; clr_req = 1;
        tick();
        chk("t3a_set_first_s", s_out, 4'b0010);
        chk("t3a_set_first_r", r_out, 0);
        wait_resp(cyc, f);
        chk("t3a_set_resp", f, 3'b100);
        set_req = 0;
        tick();
        chk("t3a_idle_gap", busy, 0);
        tick();
        chk("t3a_clr_r", r_out, 4'b1000);
        chk("t3a_clr_s", s_out, 0);
        wait_resp(cyc, f);
        chk("t3a_clr_resp", f, 3'b010);
        clr_req = 0;
        tick();
        chk("t3a_q3_cleared", q_in[3], 0);

        set_idx = 1; set_req = 1; clr_idx = 3; clr_req = 1;
        tick();
        chk("t3b_clr_first_r", r_out, 4'b1000);
        chk("t3b_clr_first_s", s_out, 0);
        wait_resp(cyc, f);
        chk("t3b_clr_resp", f, 3'b010);
        clr_req = 0;
        tick(); tick();
        chk("t3b_set_s", s_out, 4'b0010);
        wait_resp(cyc, f);
        chk("t3b_set_resp", f, 3'b100);
        set_req = 0;
        tick();

        // Flag 0 stuck at 0: SET must time out
        stuck0 = 1; set_idx = 0; set_req = 1;
        tick();
        chk("t4_drive_s", s_out, 4'b0001);
        wait_resp(cyc, f);
        chk("t4_resp_err_only", f, 3'b001);
        chk("t4_timeout_cycles", cyc, TO + 1);
        set_req = 0;
        tick();
        stuck0 = 0;

        // Three-flag instance: CLEAR of nonexistent flag 3
        clr_idx3 = 3; clr_req3 = 1;
        tick();
        chk("t5_err", {set_ack3, clr_ack3, err3}, 3'b001);
        chk("t5_busy", busy3, 1);
        chk("t5_r_out", r_out3, 0);
        clr_req3 = 0;
        tick();
        chk("t5_err_pulse", err3, 0);
        chk("t5_busy_low", busy3, 0);
        chk("t5_r_out_after", r_out3, 0);

        // Random traffic against a transaction-level model
        rst = 1'b1; tick(); rst = 1'b0;
        prev_busy = 0; m_prio_set = 1; m_active = 0; m_side_set = 0; m_exp_err = 0;
        m_idx = '0; m_pulses = 0; m_dur = 0; nreq = 0; nresp = 0;
        for (int i = 0; i < 2100; i++) begin
            tick();
            dropped_s = 0; dropped_c = 0;
            chk("t6_s_and_r", s_out & r_out, 0);
            chk("t6_s_onehot", ($countones(s_out) <= 1), 1);
            chk("t6_r_onehot", ($countones(r_out) <= 1), 1);

            if (!prev_busy && (set_req || clr_req)) begin
                chk("t6_grant_taken", busy, 1);
                if (set_req && clr_req) begin
                    gs         = m_prio_set;
                    m_prio_set = !m_prio_set;
                end else begin
                    gs = set_req;
                end
                m_active   = 1;
                m_side_set = gs;
                m_idx      = gs ? set_idx : clr_idx;
                m_exp_err  = gs && stuck0 && (m_idx == 0);
                m_pulses   = 0;
                m_dur      = 0;
            end else if (!prev_busy) begin
                chk("t6_idle_stays_idle", busy, 0);
            end

            if (m_active) begin
                m_dur++;
                if ((s_out | r_out) != 0) begin
                    m_pulses++;
                    chk("t6_pulse", {s_out, r_out},
                        m_side_set ? {oh(m_idx), NF'(0)} : {NF'(0), oh(m_idx)});
                end
                if (set_ack || clr_ack || err) begin
                    chk("t6_resp", {set_ack, clr_ack, err},
                        m_exp_err ? 3'b001 : (m_side_set ? 3'b100 : 3'b010));
                    chk("t6_pulse_count", m_pulses, 1);
                    if (m_side_set) begin set_req = 0; dropped_s = 1; end
                    else            begin clr_req = 0; dropped_c = 1; end
                    m_active = 0;
                    nresp++;
                end else begin
                    chk("t6_op_bound", (m_dur <= TO + 3), 1);
                end
            end else begin
                chk("t6_no_stray_resp", {set_ack, clr_ack, err}, 3'b000);
            end
            prev_busy = busy;

            if (i >= 1000 && !stuck0 && !m_active) stuck0 = 1;
            if (i < 2000) begin
                if (!set_req && !dropped_s && $urandom_range(3) == 0) begin
                    set_idx = IW'($urandom_range(NF - 1));
                    set_req = 1;
                    nreq++;
                end
                if (!clr_req && !dropped_c && $urandom_range(3) == 0) begin
                    clr_idx = IW'($urandom_range(NF - 1));
                    clr_req = 1;
                    nreq++;
                end
            end else if (!set_req && !clr_req && !m_active) begin
                break;
            end
        end
        chk("t6_all_served", nresp, nreq);
        chk("t6_no_pending", {set_req, clr_req}, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
